// File: rtl/q_acc_pkg.sv
// Shared constants and types for the Q-result stream accumulator.
// Saturation is selected at build time with Q_ACC_SATURATE_EN (see q_acc_add).
package q_acc_pkg;

  localparam int unsigned CNT_W             = 8;
  localparam int unsigned DEFAULT_DATA_W    = 32;
  localparam int unsigned DEFAULT_GROUP_LEN = 4;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/q_acc_add.sv
// Unsigned adder with carry out for the group accumulator.
// Q_ACC_SATURATE_EN clamps the sum to all ones whenever the add carries.
module q_acc_add #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              carry
);

  logic [DATA_W:0] raw;

  assign raw   = {1'b0, a} + {1'b0, b};
  assign carry = raw[DATA_W];

`ifdef Q_ACC_SATURATE_EN
  // A saturated accumulator stays at all ones for the rest of the group.
  assign sum = carry ? {DATA_W{1'b1}} : raw[DATA_W-1:0];
`else
  assign sum = raw[DATA_W-1:0];
`endif

endmodule

// File: rtl/q_stream_accumulator.sv
// Sums groups of GROUP_LEN Q results into a registered S stream with overflow flag.
// Build option Q_ACC_SATURATE_EN (in q_acc_add) saturates overflowing groups.
module q_stream_accumulator
  import q_acc_pkg::*;
#(
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned GROUP_LEN = DEFAULT_GROUP_LEN
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] Q,
  input  logic              Q_valid,
  output logic              Q_ready,
  output logic [DATA_W-1:0] S,
  output logic              S_valid,
  input  logic              S_ready,
  output logic              S_ovf
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(GROUP_LEN - 1);

  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q;
  logic              ovf_acc_q;
  logic [DATA_W-1:0] s_q;
  logic              s_ovf_q;
  out_state_e        out_state_q;

  logic [DATA_W-1:0] sum;
  logic              carry;
  logic              last_beat;
  logic              accept;
  logic              take;

  q_acc_add #(
    .DATA_W(DATA_W)
  ) u_add (
    .a    (acc_q),
    .b    (Q),
    .sum  (sum),
    .carry(carry)
  );

  assign S_valid   = (out_state_q == OUT_FULL);
  assign S         = s_q;
  assign S_ovf     = s_ovf_q;
  assign last_beat = (cnt_q == LastCnt);
  // Only a completing beat can be blocked; earlier beats go into acc regardless.
  assign Q_ready   = !(S_valid && !S_ready && last_beat);
  assign accept    = Q_valid && Q_ready;
  assign take      = S_valid && S_ready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      s_q         <= '0;
      s_ovf_q     <= 1'b0;
      out_state_q <= OUT_EMPTY;
    end else begin
      if (accept) begin
        if (last_beat) begin
          s_q       <= sum;
          s_ovf_q   <= ovf_acc_q | carry;
          acc_q     <= '0;
          ovf_acc_q <= 1'b0;
          cnt_q     <= '0;
        end else begin
          acc_q     <= sum;
          ovf_acc_q <= ovf_acc_q | carry;
          cnt_q     <= cnt_q + 1'b1;
        end
      end

      if (accept && last_beat) begin
        out_state_q <= OUT_FULL;
      end else if (take) begin
        out_state_q <= OUT_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_q_stream_accumulator.sv
// Randomised and directed bench for q_stream_accumulator against a queue-based group-sum model.
// Honours Q_ACC_SATURATE_EN when it is defined for the build.
module tb_q_stream_accumulator;

  localparam int unsigned DW = 32;
  localparam int unsigned GL = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] Q;
  logic          Q_valid;
  logic          Q_ready;
  logic [DW-1:0] S;
  logic          S_valid;
  logic          S_ready;
  logic          S_ovf;

  q_stream_accumulator #(
    .DATA_W   (DW),
    .GROUP_LEN(GL)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .Q      (Q),
    .Q_valid(Q_valid),
    .Q_ready(Q_ready),
    .S      (S),
    .S_valid(S_valid),
    .S_ready(S_ready),
    .S_ovf  (S_ovf)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: beats of the current group, plus the one sum waiting downstream.
  logic [DW-1:0] grp[$];
  logic          exp_valid = 1'b0;
  logic [DW-1:0] exp_s     = '0;
  logic          exp_ovf   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic group_result(output logic [DW-1:0] s, output logic ovf);
    logic [63:0] total = 64'd0;
    foreach (grp[i]) total += 64'(grp[i]);
    ovf = (total > 64'(32'hFFFF_FFFF));
`ifdef Q_ACC_SATURATE_EN
    s = ovf ? '1 : total[DW-1:0];
`else
    s = total[DW-1:0];
`endif
  endtask

  task automatic step(input logic [DW-1:0] q, input logic qv, input logic sr, input logic rst,
                      output logic accepted);
    logic exp_ready;
    logic take;
    logic [DW-1:0] ns;
    logic nov;
    @(negedge aclk);
    Q = q; Q_valid = qv; S_ready = sr; areset = rst;
    #1;
    exp_ready = !(exp_valid && !sr && grp.size() == GL - 1);
    check("q_ready", 64'(Q_ready), 64'(exp_ready));
    check("s_valid", 64'(S_valid), 64'(exp_valid));
    if (exp_valid) begin
      check("s_value", 64'(S), 64'(exp_s));
      check("s_ovf", 64'(S_ovf), 64'(exp_ovf));
    end
    accepted = qv && exp_ready && !rst;
    take     = exp_valid && sr;
    @(posedge aclk);
    if (rst) begin
      grp.delete();
      exp_valid = 1'b0;
      exp_s     = '0;
      exp_ovf   = 1'b0;
    end else begin
      if (accepted) grp.push_back(q);
      if (grp.size() == GL) begin
        group_result(ns, nov);
        exp_s = ns; exp_ovf = nov; exp_valid = 1'b1;
        grp.delete();
      end else if (take) begin
        exp_valid = 1'b0;
      end
    end
  endtask

  task automatic beats4(input logic [DW-1:0] a, b, c, d);
    logic ok;
    step(a, 1'b1, 1'b1, 1'b0, ok);
    step(b, 1'b1, 1'b1, 1'b0, ok);
    step(c, 1'b1, 1'b1, 1'b0, ok);
    step(d, 1'b1, 1'b1, 1'b0, ok);
  endtask

  initial begin
    logic ok;
    areset = 1'b1; Q = '0; Q_valid = 1'b0; S_ready = 1'b0;
    step('0, 1'b0, 1'b0, 1'b1, ok);
    step('0, 1'b0, 1'b0, 1'b1, ok);
    @(negedge aclk); areset = 1'b0; #1;
    check("rst_q_ready", 64'(Q_ready), 64'd1);
    check("rst_s_valid", 64'(S_valid), 64'd0);
    check("rst_s", 64'(S), 64'd0);
    check("rst_s_ovf", 64'(S_ovf), 64'd0);

    // Basic sum, then idle so S_valid must drop after one cycle.
    beats4(32'd2, 32'd4, 32'd6, 32'd8);
    check("basic_model", 64'(exp_s), 64'd20);
    step('0, 1'b0, 1'b1, 1'b0, ok);
    step('0, 1'b0, 1'b1, 1'b0, ok);

    // Overflow group.
    beats4(32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0);
    step('0, 1'b0, 1'b1, 1'b0, ok);

    // Backpressure: sum 20 held while three beats of the next group go in.
    beats4(32'd2, 32'd4, 32'd6, 32'd8);
    for (int i = 0; i < 3; i++) begin
      step(32'd1, 1'b1, 1'b0, 1'b0, ok);
      check("bp_accept", 64'(ok), 64'd1);
    end
    step(32'd1, 1'b1, 1'b0, 1'b0, ok);
    check("bp_stall", 64'(ok), 64'd0);
    check("bp_held", 64'(S), 64'd20);
    // Take and completing beat together: no bubble.
    step(32'd1, 1'b1, 1'b1, 1'b0, ok);
    check("bp_release", 64'(ok), 64'd1);
    step('0, 1'b0, 1'b1, 1'b0, ok);
    check("bp_second", 64'(S), 64'd4);

    // Reset mid-group.
    step(32'd7, 1'b1, 1'b1, 1'b0, ok);
    step(32'd9, 1'b1, 1'b1, 1'b0, ok);
    step('0, 1'b0, 1'b1, 1'b1, ok);
    beats4(32'd1, 32'd1, 32'd1, 32'd1);
    step('0, 1'b0, 1'b1, 1'b0, ok);
    check("rst_mid_sum", 64'(S), 64'd4);

    // Gapped input with junk on Q while Q_valid is low.
    for (int i = 0; i < 8; i++) begin
      step((i % 2 == 0) ? 32'd3 : $urandom, (i % 2 == 0), 1'b1, 1'b0, ok);
    end
    step('0, 1'b0, 1'b0, 1'b0, ok);
    check("gap_sum", 64'(S), 64'd12);

    for (int i = 0; i < 3000; i++) begin
      logic [DW-1:0] q;
      q = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
      step(q, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           ($urandom_range(0, 127) == 0), ok);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
